conbus_arb_rr: RTL and testbench
================================

# conbus_arb_rr

Round-robin Wishbone bus arbiter with stall watchdog for the shared-bus interconnect. It decides which master owns the shared bus, using a one-hot `gnt` that the interconnect ANDs into its master mux. Ownership is held for a whole `cyc` cycle. If a granted transfer sees no `ack` for `TIMEOUT` cycles, the block terminates it with a one-cycle `err` and keeps the bus masked until the master releases it. It sits beside the interconnect, replacing the fixed-priority arbiter.

## Interface
- `N_MASTERS`, 2: number of requesting masters, 2..8.
- `IDX_W`, 1: master index width; must be ≥ clog2(`N_MASTERS`).
- `TIMEOUT`, 255: stall cycles before a transfer is aborted; 0 disables the watchdog.
- `CNT_W`, 8: stall counter width; `TIMEOUT` < 2^`CNT_W`.

Ports:
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `req`  in  `N_MASTERS`  per-master `cyc` request.
- `stb`  in  1  `stb` of the currently granted master, as seen on the shared bus.
- `ack`  in  1  OR of all slave acks (the shared bus ack).
- `gnt`  out  `N_MASTERS`  one-hot grant, or all-zero when the bus is idle.
- `err`  out  `N_MASTERS`  one-cycle error termination to the holder.
- `mask`  out  1  when high, the integrator gates slave `stb`/`cyc` and master `ack` with ~`mask`.
- `to_count`  out  16  saturating count of timeouts.
- `last_to`  out  `IDX_W`  index of the master that last timed out.

## Operation
- **States:** IDLE, BUSY, ERR, DRAIN.
- **Reset values:** state=IDLE, `gnt`=0, `err`=0, `mask`=0, stall counter=0, `to_count`=0, `last_to`=0.
- **Registers:** `holder` (index of the last granted master; reset value 0). All outputs are registered or decoded from state only; there is no combinational path from `req`, `stb` or `ack` to any output.
- **Round-robin pick:** search `req` starting at `holder`+1 and wrapping modulo `N_MASTERS`. `holder` itself is checked last.
- **IDLE:** `gnt`=0.
  - If `req` is nonzero, set `gnt` to the one-hot of the pick, update `holder`, and go to BUSY.
- **BUSY:** `gnt` holds while `req[holder]`=1.
  - When `req[holder]` drops: if any other request is pending, re-grant to the pick in the same edge (zero dead cycles) and stay in BUSY; otherwise `gnt`=0 and go to IDLE.
- **Stall counter:** increments on each cycle where stall = BUSY & `req[holder]` & `stb` & !`ack`.
  - Clears on any cycle where stall is false, and on every grant change.
- **Timeout:** with `TIMEOUT`≠0, when stall is true and counter == `TIMEOUT`-1, go to ERR.
  - On that edge, increment `to_count` (saturating at 0xFFFF) and load `last_to`=`holder`.
- **ERR:** lasts exactly one cycle.
  - `err[holder]`=1, `mask`=1, `gnt` unchanged.
  - Any `ack` in this cycle is masked from the master.
  - Always go to DRAIN.
- **DRAIN:** `mask`=1 and `gnt` unchanged until `req[holder]`=0, then re-arbitrate exactly as on a BUSY release.
- **Non-holder requests** never pre-empt the holder. The grant changes only on release.

## Timing
- **Grant latency from idle:** 1 cycle (`req` sampled at edge k, `gnt` valid after edge k).
- **Back-to-back handover:** the holder drops `req` at edge k; the next grant is valid after edge k, with no idle cycle.
- **Timeout placement:** with stall true in cycles 0..`TIMEOUT`-1, `err` and `mask` are high in cycle `TIMEOUT`.
- **Ack on the last stall cycle:** an `ack` in cycle `TIMEOUT`-1 makes stall false, so there is no timeout.
- **Minimum mask length:** 2 cycles (ERR plus one DRAIN cycle, if `req` is already low).
- **Reset mid-operation:** reset is synchronous; the state after the reset edge is exactly the reset values, with `gnt`=0 for at least one cycle.

## Test plan
- **Round-robin fairness:** `N_MASTERS`=3, `req`=3'b111 held, and each holder drops `req` for 1 cycle after 4 granted cycles. Required grant sequence: 001→010→100→001, with no idle cycles between grants.
- **Idle latency:** from reset, raise `req`=2'b10 at cycle 5. Required: `gnt`=2'b10 from cycle 6; drop `req` at cycle 10; `gnt`=0 from cycle 11.
- **Timeout:** `TIMEOUT`=4, master 1 granted, `stb`=1, no `ack`. Required: `err`=2'b10 and `mask`=1 exactly 4 cycles after `stb` rises. Then `to_count`=1, `last_to`=1, and `mask` stays 1 until `req[1]` drops.
- **Late ack:** `TIMEOUT`=4, `ack` in the 4th stall cycle. Required: no `err` and `to_count` stays 0. A second 3-cycle stall with `ack` must not accumulate from the first: the counter restarts at 0.
- **Saturation and disable:** preload 65535 timeouts; one more leaves `to_count`=0xFFFF. With `TIMEOUT`=0, a 1000-cycle stall produces no `err`.
- **Reset mid-transfer:** assert `sys_rst` for 1 cycle during DRAIN. Required: `gnt`=0, `mask`=0, `err`=0 and `to_count`=0 the next cycle; then a normal 1-cycle grant.

Source files
------------

// File: rtl/conbus_arb_rr.sv
// Round-robin Wishbone bus arbiter with a stall watchdog.
// Grants are held for a whole cyc; a stalled transfer is ended with a one-cycle err and masked.
module conbus_arb_rr #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned IDX_W     = 1,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 stb,
  input  logic                 ack,
  output logic [N_MASTERS-1:0] gnt,
  output logic [N_MASTERS-1:0] err,
  output logic                 mask,
  output logic [15:0]          to_count,
  output logic [IDX_W-1:0]     last_to
);

  typedef enum logic [1:0] {StIdle, StBusy, StErr, StDrain} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     holder_q, holder_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]          to_count_q, to_count_d;
  logic [IDX_W-1:0]     last_to_q, last_to_d;

  logic [N_MASTERS-1:0] holder_oh;
  logic                 req_hold;
  logic                 stall;

  logic [IDX_W:0]       start;
  logic [IDX_W:0]       sum;
  logic [IDX_W-1:0]     off;
  logic [N_MASTERS-1:0] req_rot;
  logic [IDX_W-1:0]     pick;
  logic [N_MASTERS-1:0] pick_oh;
  logic                 pick_vld;

  assign holder_oh = N_MASTERS'(1) << holder_q;
  assign req_hold  = |(req & holder_oh);
  assign stall     = (state_q == StBusy) && req_hold && stb && !ack;

  // Rotate req so the master after the holder sits at bit 0; the holder lands at the top bit
  // and is therefore checked last.
  always_comb begin
    start = {1'b0, holder_q} + (IDX_W+1)'(1);
    if (start >= (IDX_W+1)'(N_MASTERS)) start = '0;
    req_rot  = N_MASTERS'({req, req} >> start);
    pick_vld = |req;
    off      = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (req_rot[k]) off = IDX_W'(k);
    end
    sum = start + {1'b0, off};
    if (sum >= (IDX_W+1)'(N_MASTERS)) sum = sum - (IDX_W+1)'(N_MASTERS);
    pick    = sum[IDX_W-1:0];
    pick_oh = N_MASTERS'(1) << pick;
  end

  always_comb begin
    state_d    = state_q;
    holder_d   = holder_q;
    gnt_d      = gnt_q;
    cnt_d      = '0;
    to_count_d = to_count_q;
    last_to_d  = last_to_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          gnt_d    = pick_oh;
          holder_d = pick;
          state_d  = StBusy;
        end
      end
      StBusy, StDrain: begin
        if (!req_hold) begin
          // Release: hand straight over to the next requester, or go idle.
          if (pick_vld) begin
            gnt_d    = pick_oh;
            holder_d = pick;
            state_d  = StBusy;
          end else begin
            gnt_d   = '0;
            state_d = StIdle;
          end
        end else if (stall) begin
          if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d    = StErr;
            to_count_d = (to_count_q == 16'hFFFF) ? to_count_q : to_count_q + 16'd1;
            last_to_d  = holder_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StErr: state_d = StDrain;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      holder_q   <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      to_count_q <= '0;
      last_to_q  <= '0;
    end else begin
      state_q    <= state_d;
      holder_q   <= holder_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      to_count_q <= to_count_d;
      last_to_q  <= last_to_d;
    end
  end

  assign gnt      = gnt_q;
  assign err      = (state_q == StErr) ? holder_oh : '0;
  assign mask     = (state_q == StErr) || (state_q == StDrain);
  assign to_count = to_count_q;
  assign last_to  = last_to_q;

endmodule

// File: tb/tb_conbus_arb_rr.sv
// Directed bench for conbus_arb_rr: a per-cycle vector table on a 2-master instance,
// plus hand-written sequences for saturation, 3-master fairness and a disabled watchdog.
module tb_conbus_arb_rr;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        sys_rst;
  logic        stb, ack;
  logic [1:0]  req2, req0;
  logic [2:0]  req3;

  logic [1:0]  gnt2, err2, gnt0, err0;
  logic        mask2, mask0, last2, last0;
  logic [15:0] tc2, tc0, tc3;
  logic [2:0]  gnt3, err3;
  logic        mask3;
  logic [1:0]  last3;

  conbus_arb_rr #(.N_MASTERS(2), .IDX_W(1), .TIMEOUT(4), .CNT_W(8)) u2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req2), .stb(stb), .ack(ack),
    .gnt(gnt2), .err(err2), .mask(mask2), .to_count(tc2), .last_to(last2)
  );

  conbus_arb_rr #(.N_MASTERS(3), .IDX_W(2), .TIMEOUT(4), .CNT_W(8)) u3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req3), .stb(stb), .ack(ack),
    .gnt(gnt3), .err(err3), .mask(mask3), .to_count(tc3), .last_to(last3)
  );

  conbus_arb_rr #(.N_MASTERS(2), .IDX_W(1), .TIMEOUT(0), .CNT_W(8)) u0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req0), .stb(stb), .ack(ack),
    .gnt(gnt0), .err(err0), .mask(mask0), .to_count(tc0), .last_to(last0)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        stb;
    logic        ack;
    logic [1:0]  gnt;
    logic [1:0]  err;
    logic        mask;
    logic [15:0] tc;
    logic        last;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic [1:0] rq, input logic s, input logic a,
                     input logic [1:0] g, input logic [1:0] e, input logic m,
                     input logic [15:0] t, input logic l, input int reps);
    vec_t v;
    v.rst = r; v.req = rq; v.stb = s; v.ack = a;
    v.gnt = g; v.err = e; v.mask = m; v.tc = t; v.last = l;
    for (int i = 0; i < reps; i++) vq.push_back(v);
  endtask

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic [2:0] fexp [5];
  logic       err_seen;

  initial begin
    sys_rst = 1'b1; req2 = '0; req0 = '0; req3 = '0; stb = 1'b0; ack = 1'b0;
    fexp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

    //  rst req  stb ack | gnt   err   mask tc  last reps
    add(1, 2'b00, 0, 0,   2'b00, 2'b00, 0,  0,  0,   1);  // reset
    add(0, 2'b00, 0, 0,   2'b00, 2'b00, 0,  0,  0,   4);
    add(0, 2'b10, 0, 0,   2'b10, 2'b00, 0,  0,  0,   4);  // 1-cycle grant latency
    add(0, 2'b00, 0, 0,   2'b00, 2'b00, 0,  0,  0,   2);  // release to idle
    add(0, 2'b10, 0, 0,   2'b10, 2'b00, 0,  0,  0,   1);
    add(0, 2'b10, 1, 0,   2'b10, 2'b00, 0,  0,  0,   3);  // stall cycles 0..2
    add(0, 2'b10, 1, 0,   2'b10, 2'b10, 1,  1,  1,   1);  // stall 3 -> ERR
    add(0, 2'b10, 1, 0,   2'b10, 2'b00, 1,  1,  1,   1);  // DRAIN
    add(0, 2'b10, 0, 0,   2'b10, 2'b00, 1,  1,  1,   1);
    add(0, 2'b00, 0, 0,   2'b00, 2'b00, 0,  1,  1,   1);
    add(0, 2'b10, 0, 0,   2'b10, 2'b00, 0,  1,  1,   1);
    add(0, 2'b10, 1, 0,   2'b10, 2'b00, 0,  1,  1,   3);
    add(0, 2'b10, 1, 1,   2'b10, 2'b00, 0,  1,  1,   1);  // ack on last stall cycle
    add(0, 2'b10, 1, 0,   2'b10, 2'b00, 0,  1,  1,   3);  // counter restarts
    add(0, 2'b10, 1, 1,   2'b10, 2'b00, 0,  1,  1,   1);
    add(0, 2'b10, 1, 0,   2'b10, 2'b00, 0,  1,  1,   1);
    add(0, 2'b00, 0, 0,   2'b00, 2'b00, 0,  1,  1,   1);
    add(0, 2'b01, 0, 0,   2'b01, 2'b00, 0,  1,  1,   1);
    add(0, 2'b01, 1, 0,   2'b01, 2'b00, 0,  1,  1,   3);
    add(0, 2'b01, 1, 0,   2'b01, 2'b01, 1,  2,  0,   1);  // ERR on master 0
    add(0, 2'b01, 1, 0,   2'b01, 2'b00, 1,  2,  0,   1);  // DRAIN
    add(1, 2'b01, 1, 0,   2'b00, 2'b00, 0,  0,  0,   1);  // reset mid-drain
    add(0, 2'b01, 0, 0,   2'b01, 2'b00, 0,  0,  0,   1);
    add(0, 2'b00, 0, 0,   2'b00, 2'b00, 0,  0,  0,   1);
    add(0, 2'b11, 0, 0,   2'b10, 2'b00, 0,  0,  0,   2);
    add(0, 2'b01, 0, 0,   2'b01, 2'b00, 0,  0,  0,   1);  // zero-gap handover
    add(0, 2'b11, 0, 0,   2'b01, 2'b00, 0,  0,  0,   1);  // no pre-emption
    add(0, 2'b10, 0, 0,   2'b10, 2'b00, 0,  0,  0,   1);
    add(0, 2'b00, 0, 0,   2'b00, 2'b00, 0,  0,  0,   1);
    add(0, 2'b10, 0, 0,   2'b10, 2'b00, 0,  0,  0,   1);
    add(0, 2'b10, 1, 0,   2'b10, 2'b00, 0,  0,  0,   3);
    add(0, 2'b10, 1, 0,   2'b10, 2'b10, 1,  1,  1,   1);
    add(0, 2'b11, 0, 0,   2'b10, 2'b00, 1,  1,  1,   1);  // DRAIN holds while req[1]
    add(0, 2'b01, 0, 0,   2'b01, 2'b00, 0,  1,  1,   1);  // DRAIN release re-grants
    add(0, 2'b00, 0, 0,   2'b00, 2'b00, 0,  1,  1,   1);

    foreach (vq[i]) begin
      sys_rst = vq[i].rst; req2 = vq[i].req; stb = vq[i].stb; ack = vq[i].ack;
      step();
      chk($sformatf("v%0d gnt", i),  {14'd0, gnt2}, {14'd0, vq[i].gnt});
      chk($sformatf("v%0d err", i),  {14'd0, err2}, {14'd0, vq[i].err});
      chk($sformatf("v%0d mask", i), {15'd0, mask2}, {15'd0, vq[i].mask});
      chk($sformatf("v%0d to_count", i), tc2, vq[i].tc);
      chk($sformatf("v%0d last_to", i), {15'd0, last2}, {15'd0, vq[i].last});
    end

    // Saturation: preload the count just below the limit, then time out twice.
    sys_rst = 1'b0; req2 = 2'b00; stb = 1'b0; ack = 1'b0;
    force u2.to_count_q = 16'hFFFE;
    step();
    release u2.to_count_q;
    for (int t = 0; t < 2; t++) begin
      req2 = 2'b01; stb = 1'b0;
      step();
      chk($sformatf("sat%0d gnt", t), {14'd0, gnt2}, 16'h0001);
      stb = 1'b1;
      for (int c = 0; c < 4; c++) step();
      chk($sformatf("sat%0d err", t), {14'd0, err2}, 16'h0001);
      chk($sformatf("sat%0d to_count", t), tc2, 16'hFFFF);
      req2 = 2'b00; stb = 1'b0;
      step();
      chk($sformatf("sat%0d drain mask", t), {15'd0, mask2}, 16'h0001);
      step();
      chk($sformatf("sat%0d idle mask", t), {15'd0, mask2}, 16'h0000);
    end

    // Three-master fairness; first force the pointer to master 2 so the cycle starts at 001.
    req3 = 3'b100;
    step();
    chk("fair pre gnt", {13'd0, gnt3}, 16'h0004);
    req3 = 3'b000;
    step();
    chk("fair idle gnt", {13'd0, gnt3}, 16'h0000);
    req3 = 3'b111;
    step();
    chk("fair g0", {13'd0, gnt3}, {13'd0, fexp[0]});
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        chk($sformatf("fair hold%0d.%0d", k, c), {13'd0, gnt3}, {13'd0, fexp[k]});
      end
      req3 = 3'b111 & ~fexp[k];
      step();
      chk($sformatf("fair handover%0d", k), {13'd0, gnt3}, {13'd0, fexp[k+1]});
      req3 = 3'b111;
    end
    req3 = 3'b000;
    step();
    chk("fair end gnt", {13'd0, gnt3}, 16'h0000);

    // Watchdog disabled: a long stall never terminates.
    req0 = 2'b01;
    step();
    chk("wd_off gnt", {14'd0, gnt0}, 16'h0001);
    stb = 1'b1; ack = 1'b0; err_seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (err0 != 2'b00 || mask0) err_seen = 1'b1;
    end
    chk("wd_off err_or_mask", {15'd0, err_seen}, 16'h0000);
    chk("wd_off gnt held", {14'd0, gnt0}, 16'h0001);
    chk("wd_off to_count", tc0, 16'h0000);
    stb = 1'b0; req0 = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
